conv_apb_master: RTL and testbench

APB requester that drives the convolution accelerator's APB register file: CPU-side stub, SoC bridge, or bench driver. It accepts one register transaction at a time over a valid/ready request port and generates the APB SETUP and ACCESS phases. It returns the read data, or a write completion, on a valid/ready response port. A hardware poll mode repeats a read until masked bits are set, so the host need not spin on status registers such as F_writedone at 0x20 or transmit_done at 0x2C.

---
 rtl/conv_apb_master_if.sv | 34 +++
 rtl/conv_apb_master.sv | 179 +++++++++++++++++
 tb/tb_conv_apb_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_apb_master_if.sv
// conv_apb_master_if: request/response handshake and APB bus of conv_apb_master.
// master = requester side (the DUT), slave = host and APB completer side.
interface conv_apb_master_if;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_poll;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [DW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  modport master (
    input  req_valid, req_write, req_poll, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_poll, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/conv_apb_master.sv
// conv_apb_master: single-outstanding APB requester with a hardware poll mode.
// Define APB_TIMEOUT_EN to bound ACCESS-phase waits to TIMEOUT cycles.
module conv_apb_master #(
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic               PCLK,
  input  logic               PRESETB,
  conv_apb_master_if.master  bus
);
  localparam int unsigned    DW           = 32;
  localparam int unsigned    CW           = 16;
  localparam int unsigned    GW           = 8;
  localparam bit             GAP_EN       = (POLL_GAP != 0);
  localparam logic [DW-1:0]  TIMEOUT_DATA = 32'hDEAD_BEEF;

  if (POLL_MAX == 0 || POLL_MAX > 65535 || POLL_GAP > 255 ||
      TIMEOUT == 0 || TIMEOUT > 65535) begin : g_param_check
    $error("conv_apb_master: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_POLL_WAIT,
    S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          write_q, write_nxt;
  logic          poll_q, poll_nxt;
  logic [CW-1:0] poll_cnt, poll_cnt_nxt, poll_cnt_inc;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          err_nxt;
  logic          masked_zero;
  logic          apb_on;
  logic [DW-1:0] paddr_nxt, pwdata_nxt;
  logic          pwrite_nxt;
`ifdef APB_TIMEOUT_EN
  logic [CW-1:0] to_cnt, to_cnt_nxt;
`endif

  // State, latched request fields and registered outputs
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      poll_q        <= 1'b0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.PADDR     <= '0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
    end else begin
      state         <= state_nxt;
      addr_q        <= addr_nxt;
      wdata_q       <= wdata_nxt;
      write_q       <= write_nxt;
      poll_q        <= poll_nxt;
      poll_cnt      <= poll_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
`ifdef APB_TIMEOUT_EN
      to_cnt        <= to_cnt_nxt;
`endif
      bus.req_ready <= (state_nxt == S_IDLE);
      bus.rsp_valid <= (state_nxt == S_RESP);
      bus.rsp_rdata <= rdata_nxt;
      bus.rsp_err   <= err_nxt;
      bus.busy      <= (state_nxt != S_IDLE);
      bus.PADDR     <= paddr_nxt;
      bus.PSEL      <= apb_on;
      bus.PENABLE   <= (state_nxt == S_ACCESS);
      bus.PWRITE    <= pwrite_nxt;
      bus.PWDATA    <= pwdata_nxt;
    end
  end

  // Next state, next datapath values and next registered outputs
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    write_nxt    = write_q;
    poll_nxt     = poll_q;
    poll_cnt_nxt = poll_cnt;
    gap_cnt_nxt  = gap_cnt;
    rdata_nxt    = bus.rsp_rdata;
    err_nxt      = bus.rsp_err;
`ifdef APB_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
`endif
    poll_cnt_inc = (poll_cnt == '1) ? poll_cnt : poll_cnt + CW'(1);
    masked_zero  = ((bus.PRDATA & wdata_q) == '0);

    case (state)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          addr_nxt     = bus.req_addr;
          wdata_nxt    = bus.req_wdata;
          write_nxt    = bus.req_write;
          poll_nxt     = bus.req_poll & ~bus.req_write;
          poll_cnt_nxt = '0;
          state_nxt    = S_SETUP;
        end
      end
      S_SETUP: begin
`ifdef APB_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          rdata_nxt    = write_q ? '0 : bus.PRDATA;
          err_nxt      = 1'b0;
          poll_cnt_nxt = poll_cnt_inc;
          gap_cnt_nxt  = '0;
          // poll_q is only ever set for reads
          if (poll_q && masked_zero) begin
            if (poll_cnt_inc < CW'(POLL_MAX)) begin
              state_nxt = GAP_EN ? S_POLL_WAIT : S_SETUP;
            end else begin
              state_nxt = S_RESP;
              err_nxt   = 1'b1;
            end
          end else begin
            state_nxt = S_RESP;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = S_RESP;
          rdata_nxt = TIMEOUT_DATA;
          err_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + CW'(1);
        end
`endif
      end
      S_POLL_WAIT: begin
        if (gap_cnt == GW'(POLL_GAP - 1)) begin
          state_nxt = S_SETUP;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // APB address/data/direction read as zero whenever the bus is not selected
    apb_on     = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
    paddr_nxt  = apb_on ? addr_nxt  : '0;
    pwdata_nxt = apb_on ? wdata_nxt : '0;
    pwrite_nxt = apb_on & write_nxt;
  end

endmodule

// File: tb/tb_conv_apb_master.sv
// tb_conv_apb_master: scoreboard bench for conv_apb_master with a behavioural APB completer.
// Build with APB_TIMEOUT_EN defined to also exercise the ACCESS timeout.
`timescale 1ns/1ps
module tb_conv_apb_master;
  localparam int unsigned POLL_MAX = 8;
  localparam int unsigned POLL_GAP = 4;
  localparam int unsigned TIMEOUT  = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          setups;
    int          accesses;
    int          gaps;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESETB;

  conv_apb_master_if bus();

  conv_apb_master #(
    .POLL_MAX (POLL_MAX),
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .PCLK    (PCLK),
    .PRESETB (PRESETB),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rd_default = '0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          rd_base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Completer: wait_cfg wait states per transfer, read data from rd_q in order
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (wait_cnt >= wait_cfg) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = (n_rd - rd_base < rd_q.size()) ? rd_q[n_rd - rd_base] : rd_default;
      end else begin
        bus.PREADY = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.PREADY = 1'b0;
      bus.PRDATA = '0;
      wait_cnt   = 0;
    end
  end

  // Completed APB transfers
  always @(posedge PCLK) begin
    if (PRESETB && bus.PSEL && bus.PENABLE && bus.PREADY) begin
      if (bus.PWRITE) n_wr++;
      else            n_rd++;
    end
  end

  function automatic exp_t mk_exp(input logic [31:0] rdata, input logic err,
                                  input int nrd, input int nwr, input int waits);
    exp_t e;
    int   t;
    t          = nrd + nwr;
    e.rdata    = rdata;
    e.err      = err;
    e.setups   = t;
    e.accesses = t + waits;
    e.gaps     = (t - 1) * int'(POLL_GAP);
    e.lat      = 2 * t + waits + e.gaps + 1;
    e.nrd      = nrd;
    e.nwr      = nwr;
    return e;
  endfunction

  // Issue one request at the current negedge, watch the bus every cycle, retire on handshake
  task automatic run_txn(input logic wr, input logic pl, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input exp_t e_in,
                         input string name);
    exp_t        e;
    int          cyc, first_setup, first_rsp, n_setup, n_access, n_gap, n_valid;
    int          setup_bad, fld_bad, rdy_bad, stab_bad, rd0, wr0, hold_left;
    bit          done, prev_setup, prev_psel, is_setup, is_access;
    logic [31:0] rsp_d0;
    logic        rsp_e0;
    cyc = 0; first_setup = -1; first_rsp = -1; n_setup = 0; n_access = 0; n_gap = 0;
    n_valid = 0; setup_bad = 0; fld_bad = 0; rdy_bad = 0; stab_bad = 0;
    hold_left = hold; done = 1'b0; prev_setup = 1'b0; prev_psel = 1'b0;
    rsp_d0 = '0; rsp_e0 = 1'b0;
    rd0 = n_rd; wr0 = n_wr; rd_base = n_rd;

    exp_q.push_back(e_in);
    bus.req_write = wr;
    bus.req_poll  = pl;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;

    while (!done && cyc < 300) begin
      @(negedge PCLK);
      cyc++;
      bus.req_valid = 1'b0;
      is_setup  = bus.PSEL && !bus.PENABLE;
      is_access = bus.PSEL && bus.PENABLE;
      if (is_setup) begin
        n_setup++;
        if (first_setup < 0) first_setup = cyc;
      end
      if (prev_setup && !is_access) setup_bad++;
      if (is_access) begin
        n_access++;
        if (!prev_psel) setup_bad++;
      end
      if (!bus.PSEL && n_setup > 0 && !bus.rsp_valid) n_gap++;
      if (bus.PSEL) begin
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wd) fld_bad++;
      end else if (bus.PADDR !== '0 || bus.PWDATA !== '0 || bus.PWRITE !== 1'b0) begin
        fld_bad++;
      end
      if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) rdy_bad++;
      prev_setup = is_setup;
      prev_psel  = bus.PSEL;

      if (bus.rsp_valid) begin
        n_valid++;
        if (first_rsp < 0) begin
          first_rsp = cyc;
          rsp_d0    = bus.rsp_rdata;
          rsp_e0    = bus.rsp_err;
        end else if (bus.rsp_rdata !== rsp_d0 || bus.rsp_err !== rsp_e0) begin
          stab_bad++;
        end
        if (hold_left == 0) begin
          bus.rsp_ready = 1'b1;
          @(negedge PCLK);
          bus.rsp_ready = 1'b0;
          check({name, "_rsp_drop"}, bus.rsp_valid, 0);
          check({name, "_idle_ready"}, bus.req_ready, 1);
          done = 1'b1;
        end else begin
          hold_left--;
        end
      end
    end
    check({name, "_done"}, done, 1);

    check({name, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_first_setup"}, first_setup, 1);
      check({name, "_setups"}, n_setup, e.setups);
      check({name, "_phase_seq"}, setup_bad, 0);
      check({name, "_access_cyc"}, n_access, e.accesses);
      check({name, "_idle_gap"}, n_gap, e.gaps);
      check({name, "_bus_fields"}, fld_bad, 0);
      check({name, "_req_blocked"}, rdy_bad, 0);
      check({name, "_latency"}, first_rsp, e.lat);
      check({name, "_valid_cyc"}, n_valid, hold + 1);
      check({name, "_rsp_stable"}, stab_bad, 0);
      check({name, "_rdata"}, rsp_d0, e.rdata);
      check({name, "_err"}, rsp_e0, e.err);
      check({name, "_apb_reads"}, n_rd - rd0, e.nrd);
      check({name, "_apb_writes"}, n_wr - wr0, e.nwr);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_poll  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    PRESETB = 1'b1;
    #1 PRESETB = 1'b0;
    #1;
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_apb_fields", {bus.PWRITE, bus.PADDR | bus.PWDATA}, 0);
    repeat (3) @(negedge PCLK);
    PRESETB = 1'b1;
    @(negedge PCLK);
    check("idle_req_ready", bus.req_ready, 1);
    check("idle_busy", bus.busy, 0);

    run_txn(1'b1, 1'b0, 32'h04, 32'h3, 0, mk_exp(32'h0, 1'b0, 0, 1, 0), "write");

    rd_q = '{32'h0000_1234};
    run_txn(1'b0, 1'b0, 32'h30, 32'h0, 0, mk_exp(32'h0000_1234, 1'b0, 1, 0, 0), "read");

    rd_q = '{32'h0, 32'h0, 32'h0, 32'h1};
    run_txn(1'b0, 1'b1, 32'h20, 32'h1, 0, mk_exp(32'h1, 1'b0, 4, 0, 0), "poll");

    rd_q.delete();
    rd_default = 32'h0;
    run_txn(1'b0, 1'b1, 32'h20, 32'h1, 0, mk_exp(32'h0, 1'b1, 8, 0, 0), "poll_max");

    rd_default = 32'hFFFF_FFFF;
    run_txn(1'b0, 1'b1, 32'h2C, 32'h0, 0, mk_exp(32'hFFFF_FFFF, 1'b1, 8, 0, 0), "poll_mask0");
    rd_default = 32'h0;

    run_txn(1'b1, 1'b1, 32'h08, 32'h55, 0, mk_exp(32'h0, 1'b0, 0, 1, 0), "poll_wr");

    wait_cfg = 5;
    rd_q = '{32'hCAFE_0001};
    run_txn(1'b0, 1'b0, 32'h10, 32'h0000_A5A5, 3, mk_exp(32'hCAFE_0001, 1'b0, 1, 0, 5), "wait");
    wait_cfg = 0;

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d;
      logic        w;
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      rd_q = '{d};
      if (w) run_txn(1'b1, 1'b0, a, d, i, mk_exp(32'h0, 1'b0, 0, 1, 0), "rand_wr");
      else   run_txn(1'b0, 1'b0, a, d, i, mk_exp(d, 1'b0, 1, 0, 0), "rand_rd");
    end

    wait_cfg = 1000;
    bus.req_addr  = 32'h2C;
    bus.req_wdata = 32'h0;
    bus.req_write = 1'b0;
    bus.req_poll  = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    check("mid_rst_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESETB = 1'b0;
    #1;
    check("mid_rst_psel", bus.PSEL, 0);
    check("mid_rst_penable", bus.PENABLE, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge PCLK);
    PRESETB  = 1'b1;
    wait_cfg = 0;
    @(negedge PCLK);
    check("mid_rst_idle", bus.req_ready, 1);

    rd_q = '{32'h0BAD_F00D};
    run_txn(1'b0, 1'b0, 32'h30, 32'h0, 0, mk_exp(32'h0BAD_F00D, 1'b0, 1, 0, 0), "post_rst");

`ifdef APB_TIMEOUT_EN
    begin : tmo
      exp_t e;
      wait_cfg   = 100000;
      e          = mk_exp(32'hDEAD_BEEF, 1'b1, 0, 0, 0);
      e.setups   = 1;
      e.accesses = int'(TIMEOUT);
      e.gaps     = 0;
      e.lat      = int'(TIMEOUT) + 2;
      run_txn(1'b0, 1'b0, 32'h2C, 32'h0, 0, e, "timeout");
      wait_cfg   = 0;
    end
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
